// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for a single-port SRAM: locked bursts capped at MAX_BURST,
// otherwise round-robin on contention; read data is routed back two cycles after accept.
module sram_port_arbiter #(
  parameter int ADR_W     = 10,
  parameter int SRAM_W    = 128,
  parameter int MAX_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid_0,
  input  logic              i_req_valid_1,
  output logic              o_req_ready_0,
  output logic              o_req_ready_1,
  input  logic              i_req_wen_0,
  input  logic              i_req_wen_1,
  input  logic [ADR_W-1:0]  i_req_addr_0,
  input  logic [ADR_W-1:0]  i_req_addr_1,
  input  logic [SRAM_W-1:0] i_req_data_0,
  input  logic [SRAM_W-1:0] i_req_data_1,
  input  logic [SRAM_W-1:0] i_req_wmask_0,
  input  logic [SRAM_W-1:0] i_req_wmask_1,
  input  logic              i_req_lock_0,
  input  logic              i_req_lock_1,
  output logic              o_rsp_valid_0,
  output logic              o_rsp_valid_1,
  output logic [SRAM_W-1:0] o_rsp_data_0,
  output logic [SRAM_W-1:0] o_rsp_data_1,
  output logic              o_ram_cen,
  output logic              o_ram_rdwen,
  output logic [ADR_W-1:0]  o_ram_addr,
  output logic [SRAM_W-1:0] o_ram_indata,
  output logic [SRAM_W-1:0] o_ram_wmask,
  input  logic [SRAM_W-1:0] i_ram_outdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);

  logic              last_q, last_d;
  logic              acc_q;
  logic [CNT_W-1:0]  burst_q, burst_d;
  logic              last_valid, last_lock, lock_cont;
  logic              accept, gnt;
  logic              sel_wen;
  logic [ADR_W-1:0]  sel_addr;
  logic [SRAM_W-1:0] sel_data, sel_wmask;

  logic              cen_q, rdwen_q;
  logic [ADR_W-1:0]  addr_q;
  logic [SRAM_W-1:0] indata_q, wmask_q;
  logic              rv1_q, rid1_q, rv2_q, rid2_q;

  always_comb begin
    last_valid = last_q ? i_req_valid_1 : i_req_valid_0;
    last_lock  = last_q ? i_req_lock_1  : i_req_lock_0;
    // The lock chain only survives if the owner was accepted in the immediately preceding cycle.
    lock_cont  = acc_q && last_valid && last_lock && (burst_q < BURST_MAX);
    accept     = !i_rst && (i_req_valid_0 || i_req_valid_1);

    gnt = 1'b0;
    if (lock_cont) begin
      gnt = last_q;
    end else if (i_req_valid_0 && i_req_valid_1) begin
      gnt = ~last_q;
    end else begin
      gnt = i_req_valid_1;
    end

    last_d  = last_q;
    burst_d = burst_q;
    if (accept) begin
      last_d  = gnt;
      burst_d = lock_cont ? burst_q + BURST_ONE : BURST_ONE;
    end

    sel_wen   = gnt ? i_req_wen_1   : i_req_wen_0;
    sel_addr  = gnt ? i_req_addr_1  : i_req_addr_0;
    sel_data  = gnt ? i_req_data_1  : i_req_data_0;
    sel_wmask = gnt ? i_req_wmask_1 : i_req_wmask_0;
  end

  assign o_req_ready_0 = accept && !gnt;
  assign o_req_ready_1 = accept && gnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_q   <= 1'b1;
      acc_q    <= 1'b0;
      burst_q  <= '0;
      cen_q    <= 1'b1;
      rdwen_q  <= 1'b1;
      addr_q   <= '0;
      indata_q <= '0;
      wmask_q  <= '0;
      rv1_q    <= 1'b0;
      rid1_q   <= 1'b0;
      rv2_q    <= 1'b0;
      rid2_q   <= 1'b0;
    end else begin
      last_q  <= last_d;
      acc_q   <= accept;
      burst_q <= burst_d;
      cen_q   <= !accept;
      rv1_q   <= accept && !sel_wen;
      rid1_q  <= gnt;
      rv2_q   <= rv1_q;
      rid2_q  <= rid1_q;
      if (accept) begin
        rdwen_q  <= ~sel_wen;
        addr_q   <= sel_addr;
        indata_q <= sel_data;
        wmask_q  <= sel_wmask;
      end
    end
  end

  assign o_ram_cen     = cen_q;
  assign o_ram_rdwen   = rdwen_q;
  assign o_ram_addr    = addr_q;
  assign o_ram_indata  = indata_q;
  assign o_ram_wmask   = wmask_q;

  assign o_rsp_valid_0 = rv2_q && !rid2_q;
  assign o_rsp_valid_1 = rv2_q && rid2_q;
  assign o_rsp_data_0  = i_ram_outdata;
  assign o_rsp_data_1  = i_ram_outdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM, reference arbiter model and a
// response scoreboard keyed by requester id and due cycle.
module tb_sram_port_arbiter;
  localparam int ADR_W = 10, SRAM_W = 128, MAX_BURST = 4;
  localparam int DEPTH = 1 << ADR_W;

  logic clk = 1'b0;
  logic rst;
  logic v0, v1, w0, w1, l0, l1;
  logic [ADR_W-1:0] a0, a1;
  logic [SRAM_W-1:0] d0, d1, m0, m1;
  logic rdy0, rdy1, rsp_v0, rsp_v1;
  logic [SRAM_W-1:0] rsp_d0, rsp_d1;
  logic ram_cen, ram_rdwen;
  logic [ADR_W-1:0] ram_addr;
  logic [SRAM_W-1:0] ram_indata, ram_wmask, ram_out;

  logic [SRAM_W-1:0] mem [DEPTH];
  logic [SRAM_W-1:0] ref_mem [DEPTH];
  bit mem_init = 0;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  typedef struct { int id; logic [SRAM_W-1:0] data; int due; } rsp_t;
  rsp_t sb[$];

  bit m_last = 1, m_acc = 0;
  int m_burst = 0;

  sram_port_arbiter #(.ADR_W(ADR_W), .SRAM_W(SRAM_W), .MAX_BURST(MAX_BURST)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid_0(v0), .i_req_valid_1(v1),
    .o_req_ready_0(rdy0), .o_req_ready_1(rdy1),
    .i_req_wen_0(w0), .i_req_wen_1(w1),
    .i_req_addr_0(a0), .i_req_addr_1(a1),
    .i_req_data_0(d0), .i_req_data_1(d1),
    .i_req_wmask_0(m0), .i_req_wmask_1(m1),
    .i_req_lock_0(l0), .i_req_lock_1(l1),
    .o_rsp_valid_0(rsp_v0), .o_rsp_valid_1(rsp_v1),
    .o_rsp_data_0(rsp_d0), .o_rsp_data_1(rsp_d1),
    .o_ram_cen(ram_cen), .o_ram_rdwen(ram_rdwen), .o_ram_addr(ram_addr),
    .o_ram_indata(ram_indata), .o_ram_wmask(ram_wmask),
    .i_ram_outdata(ram_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [SRAM_W-1:0] pat(int a);
    logic [31:0] w;
    w = 32'hA5C3_0000 ^ (32'(a) * 32'h0103_0507);
    return {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'd1};
  endfunction

  function automatic logic [1:0] exp_rdy(int g);
    return (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
  endfunction

  // SRAM with registered read; bit 8k of the mask enables byte k
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = pat(i);
      mem_init = 1;
    end else if (!ram_cen) begin
      if (ram_rdwen) ram_out <= mem[ram_addr];
      else for (int k = 0; k < SRAM_W/8; k++)
        if (ram_wmask[8*k]) mem[ram_addr][8*k +: 8] = ram_indata[8*k +: 8];
    end
  end

  always @(negedge clk) begin
    rsp_t e;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL rsp_missing id=%0d due=%0d now=%0d", e.id, e.due, cyc);
    end
    if (rsp_v0 || rsp_v1) begin
      n_cmp++;
      if (rsp_v0 && rsp_v1) begin
        n_bad++; $display("FAIL rsp_both cyc=%0d got=both required=one", cyc);
      end else if (sb.size() == 0) begin
        n_bad++; $display("FAIL rsp_unexpected cyc=%0d got v0=%b v1=%b required=none", cyc, rsp_v0, rsp_v1);
      end else begin
        e = sb.pop_front();
        if ((rsp_v1 ? 1 : 0) !== e.id || (rsp_v1 ? rsp_d1 : rsp_d0) !== e.data || cyc !== e.due) begin
          n_bad++;
          $display("FAIL rsp_data cyc=%0d got id=%0d data=%h required id=%0d data=%h due=%0d",
                   cyc, rsp_v1 ? 1 : 0, rsp_v1 ? rsp_d1 : rsp_d0, e.id, e.data, e.due);
        end
      end
    end
  end

  // Reference arbiter: evaluates the current inputs, records expected effects, then waits to negedge.
  task automatic tick(output int g);
    bit lc, wen;
    logic [ADR_W-1:0] a;
    logic [SRAM_W-1:0] d, m;
    g = -1;
    if (rst) begin
      m_last = 1; m_acc = 0; m_burst = 0; sb.delete();
    end else begin
      lc = m_acc && (m_last ? (v1 && l1) : (v0 && l0)) && (m_burst < MAX_BURST);
      if (lc) g = m_last;
      else if (v0 && v1) g = m_last ? 0 : 1;
      else if (v0) g = 0;
      else if (v1) g = 1;
      if (g >= 0) begin
        m_burst = lc ? m_burst + 1 : 1;
        m_last = (g == 1);
        m_acc = 1;
        wen = (g == 1) ? w1 : w0;
        a   = (g == 1) ? a1 : a0;
        d   = (g == 1) ? d1 : d0;
        m   = (g == 1) ? m1 : m0;
        if (!wen) sb.push_back('{g, ref_mem[a], cyc + 2});
        else for (int k = 0; k < SRAM_W/8; k++)
          if (m[8*k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
      end else begin
        m_acc = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    v0 = 0; v1 = 0; w0 = 0; w1 = 0; l0 = 0; l1 = 0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0; m0 = '1; m1 = '1;
  endtask

  task automatic drain(int n);
    int g;
    idle();
    repeat (n) begin tick(g); adv(); end
  endtask

  task automatic test_reset();
    int g;
    rst = 1; v0 = 1; v1 = 1;
    for (int i = 0; i < 3; i++) begin
      tick(g);
      n_cmp++;
      if ({rdy1, rdy0} !== 2'b00) begin
        n_bad++; $display("FAIL rst_ready i=%0d got=%b required=00", i, {rdy1, rdy0});
      end
      n_cmp++;
      if ({ram_cen, ram_rdwen, ram_addr, ram_indata, ram_wmask, rsp_v0, rsp_v1} !==
          {1'b1, 1'b1, {ADR_W{1'b0}}, {SRAM_W{1'b0}}, {SRAM_W{1'b0}}, 2'b00}) begin
        n_bad++; $display("FAIL rst_outputs i=%0d got cen=%b rdwen=%b addr=%0d rsp=%b%b required cen=1 rdwen=1 addr=0 rsp=00",
                          i, ram_cen, ram_rdwen, ram_addr, rsp_v1, rsp_v0);
      end
      adv();
    end
    rst = 0;
    drain(2);
  endtask

  task automatic test_round_robin();
    int g;
    logic [1:0] exp;
    v0 = 1; v1 = 1; w0 = 0; w1 = 0; a0 = 3; a1 = 7;
    for (int i = 0; i < 6; i++) begin
      tick(g);
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++;
      if ({rdy1, rdy0} !== exp) begin
        n_bad++; $display("FAIL rr_grant i=%0d got=%b required=%b", i, {rdy1, rdy0}, exp);
      end
      if (i == 1) begin
        n_cmp++;
        if ({ram_cen, ram_rdwen, ram_addr} !== {1'b0, 1'b1, ADR_W'(3)}) begin
          n_bad++; $display("FAIL rr_ramcmd got cen=%b rdwen=%b addr=%0d required cen=0 rdwen=1 addr=3",
                            ram_cen, ram_rdwen, ram_addr);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (rsp_v0 !== 1'b1 || rsp_d0 !== pat(3)) begin
          n_bad++; $display("FAIL rr_first_rsp got v0=%b data=%h required v0=1 data=%h", rsp_v0, rsp_d0, pat(3));
        end
      end
      adv();
    end
    drain(4);
  endtask

  task automatic test_write_mask();
    int g;
    logic [SRAM_W-1:0] expd;
    expd = pat(5);
    expd[15:0] = 16'hAAAA;
    v0 = 1; w0 = 1; a0 = 5; d0 = {(SRAM_W/8){8'hAA}};
    m0 = '0; m0[0] = 1'b1; m0[8] = 1'b1;
    tick(g);
    n_cmp++;
    if ({rdy1, rdy0} !== 2'b01) begin n_bad++; $display("FAIL wm_wr_ready got=%b required=01", {rdy1, rdy0}); end
    adv();
    w0 = 0;
    tick(g);
    n_cmp++;
    if ({rdy1, rdy0} !== 2'b01) begin n_bad++; $display("FAIL wm_rd_ready got=%b required=01", {rdy1, rdy0}); end
    n_cmp++;
    if (ram_cen !== 1'b0 || ram_rdwen !== 1'b0 || ram_wmask !== m0 || ram_indata !== d0) begin
      n_bad++; $display("FAIL wm_ramcmd got cen=%b rdwen=%b wmask=%h required cen=0 rdwen=0 wmask=%h",
                        ram_cen, ram_rdwen, ram_wmask, m0);
    end
    adv();
    v0 = 0;
    tick(g);
    n_cmp++;
    if (rsp_v0 !== 1'b0 || rsp_v1 !== 1'b0) begin
      n_bad++; $display("FAIL wm_write_rsp got=%b%b required=00", rsp_v1, rsp_v0);
    end
    adv();
    tick(g);
    n_cmp++;
    if (rsp_v0 !== 1'b1 || rsp_d0 !== expd) begin
      n_bad++; $display("FAIL wm_read_rsp got v0=%b data=%h required v0=1 data=%h", rsp_v0, rsp_d0, expd);
    end
    adv();
    drain(3);
  endtask

  task automatic test_burst_lock();
    int g;
    int seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    v0 = 1; l0 = 1; w0 = 0; a0 = 20; v1 = 0; w1 = 0; a1 = 40;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) v1 = 1;
      tick(g);
      n_cmp++;
      if ({rdy1, rdy0} !== exp_rdy(seq[i])) begin
        n_bad++; $display("FAIL burst_grant i=%0d got=%b required=%b", i, {rdy1, rdy0}, exp_rdy(seq[i]));
      end
      adv();
    end
    drain(4);
  endtask

  task automatic test_single_r1();
    int g, lows;
    lows = 0;
    v1 = 1; w1 = 1; m1 = '1;
    for (int i = 0; i < 10; i++) begin
      a1 = ADR_W'(100 + i); d1 = pat(1000 + i);
      tick(g);
      n_cmp++;
      if ({rdy1, rdy0} !== 2'b10) begin
        n_bad++; $display("FAIL r1_only_ready i=%0d got=%b required=10", i, {rdy1, rdy0});
      end
      if (ram_cen === 1'b0) lows++;
      adv();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      tick(g);
      if (ram_cen === 1'b0) lows++;
      adv();
    end
    n_cmp++;
    if (lows !== 10) begin n_bad++; $display("FAIL r1_only_cen got=%0d low cycles required=10", lows); end
    drain(1);
  endtask

  task automatic test_back_to_back();
    int g;
    logic [SRAM_W-1:0] da, db;
    bit wen_s[5] = '{1, 0, 1, 0, 0};
    int adr_s[5] = '{9, 9, 9, 9, 2};
    da = pat(77); db = ~pat(78);
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        v0 = 1; w0 = wen_s[i]; a0 = ADR_W'(adr_s[i]); d0 = (i == 0) ? da : db; m0 = '1;
      end else begin
        idle();
      end
      tick(g);
      if (i < 5) begin
        n_cmp++;
        if ({rdy1, rdy0} !== 2'b01) begin
          n_bad++; $display("FAIL b2b_ready i=%0d got=%b required=01", i, {rdy1, rdy0});
        end
      end
      if (i == 3 || i == 5) begin
        n_cmp++;
        if (rsp_v0 !== 1'b1 || rsp_d0 !== ((i == 3) ? da : db)) begin
          n_bad++; $display("FAIL b2b_raw i=%0d got v0=%b data=%h required v0=1 data=%h",
                            i, rsp_v0, rsp_d0, (i == 3) ? da : db);
        end
      end
      adv();
    end
    drain(3);
  endtask

  task automatic test_reset_mid();
    int g;
    v0 = 1; w0 = 0; a0 = 12;
    tick(g);
    n_cmp++;
    if ({rdy1, rdy0} !== 2'b01) begin n_bad++; $display("FAIL rm_accept got=%b required=01", {rdy1, rdy0}); end
    adv();
    rst = 1; v0 = 1; v1 = 1;
    tick(g);
    n_cmp++;
    if ({rdy1, rdy0} !== 2'b00) begin n_bad++; $display("FAIL rm_rst_ready got=%b required=00", {rdy1, rdy0}); end
    adv();
    rst = 0; idle();
    tick(g);
    n_cmp++;
    if ({ram_cen, ram_rdwen, ram_addr, ram_indata, ram_wmask, rsp_v0, rsp_v1} !==
        {1'b1, 1'b1, {ADR_W{1'b0}}, {SRAM_W{1'b0}}, {SRAM_W{1'b0}}, 2'b00}) begin
      n_bad++; $display("FAIL rm_outputs got cen=%b rdwen=%b addr=%0d rsp=%b%b required cen=1 rdwen=1 addr=0 rsp=00",
                        ram_cen, ram_rdwen, ram_addr, rsp_v1, rsp_v0);
    end
    adv();
    tick(g);
    n_cmp++;
    if (rsp_v0 !== 1'b0 || rsp_v1 !== 1'b0) begin
      n_bad++; $display("FAIL rm_cancel got=%b%b required=00", rsp_v1, rsp_v0);
    end
    adv();
    v0 = 1; v1 = 1; a0 = 30; a1 = 31;
    tick(g);
    n_cmp++;
    if ({rdy1, rdy0} !== 2'b01) begin n_bad++; $display("FAIL rm_first_contention got=%b required=01", {rdy1, rdy0}); end
    adv();
    drain(4);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
    rst = 1;
    idle();
    adv();
    test_reset();
    test_round_robin();
    test_write_mask();
    test_burst_lock();
    test_single_r1();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++; $display("FAIL sb_empty got=%0d pending required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
